// File: rtl/rate_tick_gen.sv
// Programmable rate generator: one-cycle tick at SLOW_PERIOD >> level, level stepped by up/down buttons.
// Optional square-wave output on rate_sq is built when SQUARE_EN is defined.
module rate_tick_gen #(
    parameter int unsigned SLOW_PERIOD = 800_000_000,
    parameter int unsigned LEVELS      = 10,
    parameter int unsigned RESET_LEVEL = 4,
    parameter int unsigned CNT_W       = 30
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       en,
    input  logic       spdUp,
    input  logic       spdDown,
    output logic       rate_clk,
    output logic [3:0] level,
    output logic [6:0] HEX5,
    output logic       rate_sq
);

    localparam logic [3:0]       MAX_LEVEL  = 4'(LEVELS - 1);
    localparam logic [3:0]       INIT_LEVEL = 4'(RESET_LEVEL);
    localparam logic [CNT_W-1:0] SLOW_CNT   = CNT_W'(SLOW_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [2:0]       up_pipe;
    logic [2:0]       dn_pipe;
    logic             up_edge;
    logic             dn_edge;
    logic [3:0]       next_level;
    logic             level_change;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] period_last;
    logic             tick_set;

    // Bits [1:0] synchronise the button, bit [2] is the previous synchronised value.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            up_pipe <= 3'b000;
            dn_pipe <= 3'b000;
        end else begin
            up_pipe <= {up_pipe[1:0], spdUp};
            dn_pipe <= {dn_pipe[1:0], spdDown};
        end
    end

    assign up_edge = up_pipe[1] & ~up_pipe[2];
    assign dn_edge = dn_pipe[1] & ~dn_pipe[2];

    // A saturated request is not a change, so it leaves the counter running.
    always_comb begin
        next_level   = level;
        level_change = 1'b0;
        if (up_edge && !dn_edge) begin
            if (level != MAX_LEVEL) begin
                next_level   = level + 4'd1;
                level_change = 1'b1;
            end
        end else if (dn_edge && !up_edge) begin
            if (level != 4'd0) begin
                next_level   = level - 4'd1;
                level_change = 1'b1;
            end
        end
    end

    assign period      = SLOW_CNT >> level;
    assign period_last = period - CNT_ONE;
    assign tick_set    = en && !level_change && (count == period_last);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            level    <= INIT_LEVEL;
            count    <= '0;
            rate_clk <= 1'b0;
        end else begin
            level <= next_level;
            if (level_change) begin
                count    <= '0;
                rate_clk <= 1'b0;
            end else if (tick_set) begin
                count    <= '0;
                rate_clk <= 1'b1;
            end else if (en) begin
                count    <= count + CNT_ONE;
                rate_clk <= 1'b0;
            end else begin
                rate_clk <= 1'b0;
            end
        end
    end

`ifdef SQUARE_EN
    logic sq_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset || level_change) begin
            sq_q <= 1'b0;
        end else if (tick_set) begin
            sq_q <= ~sq_q;
        end
    end

    assign rate_sq = sq_q;
`else
    assign rate_sq = 1'b0;
`endif

    // Active-low hex glyphs, bit0 = segment a.
    always_comb begin
        HEX5 = 7'b1111111;
        case (level)
            4'h0: HEX5 = 7'b1000000;
            4'h1: HEX5 = 7'b1111001;
            4'h2: HEX5 = 7'b0100100;
            4'h3: HEX5 = 7'b0110000;
            4'h4: HEX5 = 7'b0011001;
            4'h5: HEX5 = 7'b0010010;
            4'h6: HEX5 = 7'b0000010;
            4'h7: HEX5 = 7'b1111000;
            4'h8: HEX5 = 7'b0000000;
            4'h9: HEX5 = 7'b0010000;
            4'hA: HEX5 = 7'b0001000;
            4'hB: HEX5 = 7'b0000011;
            4'hC: HEX5 = 7'b1000110;
            4'hD: HEX5 = 7'b0100001;
            4'hE: HEX5 = 7'b0000110;
            4'hF: HEX5 = 7'b0001110;
            default: HEX5 = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_rate_tick_gen.sv
// Scoreboard bench for rate_tick_gen: expected tick cycles are queued as stimulus is driven
// and popped whenever rate_clk pulses.
module tb_rate_tick_gen;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       en       = 1'b1;
    logic       spdUp    = 1'b0;
    logic       spdDown  = 1'b0;
    logic       rate_clk;
    logic [3:0] level;
    logic [6:0] HEX5;
    logic       rate_sq;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b1;
    int exp_q[$];

    rate_tick_gen #(
        .SLOW_PERIOD(1024),
        .LEVELS     (10),
        .RESET_LEVEL(4),
        .CNT_W      (11)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .en      (en),
        .spdUp   (spdUp),
        .spdDown (spdDown),
        .rate_clk(rate_clk),
        .level   (level),
        .HEX5    (HEX5),
        .rate_sq (rate_sq)
    );

    initial forever #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Each pulse is matched against the oldest expected tick cycle.
    always @(negedge CLOCK_50) begin
        if (mon_en && rate_clk === 1'b1) begin
            if (exp_q.size() == 0)
                checkOutput("stray_tick", cyc, -1);
            else
                checkOutput("tick_time", cyc, exp_q.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLOCK_50);
        #1;
    endtask

    task automatic drain();
        checkOutput("pending_ticks", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic pushTicks(input int first, input int spacing, input int count);
        for (int k = 0; k < count; k++) exp_q.push_back(first + k * spacing);
    endtask

    task automatic doReset(output int r);
        mon_en  = 1'b1;
        reset   = 1'b1;
        spdUp   = 1'b0;
        spdDown = 1'b0;
        en      = 1'b1;
        step(1);
        checkOutput("reset_rate_clk", int'(rate_clk), 0);
        checkOutput("reset_level", int'(level), 4);
        checkOutput("reset_hex", int'(HEX5), 7'b0011001);
        checkOutput("reset_rate_sq", int'(rate_sq), 0);
        step(1);
        r     = cyc;
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input logic up, input logic dn, input int hold, output int start);
        start   = cyc;
        spdUp   = up;
        spdDown = dn;
        step(hold);
        spdUp   = 1'b0;
        spdDown = 1'b0;
    endtask

    initial begin
        int r, n, lc;
        step(2);

        // Reset release at level 4: ticks every 64 cycles.
        doReset(r);
        pushTicks(r + 64, 64, 4);
        step(258);
        drain();
        checkOutput("p1_level", int'(level), 4);
        checkOutput("p1_rate_sq", int'(rate_sq), 0);

        // Step up to level 9, last press saturates.
        doReset(r);
        mon_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 5, n);
            checkOutput("p2_level_step", int'(level), 5 + i);
            step(5);
        end
        spdUp = 1'b1;
        lc    = cyc + 3;
        step(3);
        checkOutput("p2_level9", int'(level), 9);
        exp_q.delete();
        mon_en = 1'b1;
        pushTicks(lc + 2, 2, 15);
        step(2);
        spdUp = 1'b0;
        step(6);
        applyStimulus(1'b1, 1'b0, 5, n);
        step(lc + 31 - cyc);
        drain();
        checkOutput("p2_level_sat", int'(level), 9);
        checkOutput("p2_hex", int'(HEX5), 7'b0010000);

        // Step down to level 0, last press saturates at a nonzero count.
        doReset(r);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 5, n);
            step(5);
            checkOutput("p3_level_step", int'(level), 3 - i);
        end
        lc = n + 3;
        pushTicks(lc + 1024, 1024, 2);
        applyStimulus(1'b0, 1'b1, 5, n);
        step(lc + 2050 - cyc);
        drain();
        checkOutput("p3_level_sat", int'(level), 0);
        checkOutput("p3_hex", int'(HEX5), 7'b1000000);

        // Simultaneous up and down edges cancel.
        doReset(r);
        pushTicks(r + 64, 64, 3);
        step(10);
        applyStimulus(1'b1, 1'b1, 5, n);
        step(r + 194 - cyc);
        checkOutput("p4_level", int'(level), 4);
        drain();

        // Level change at count 40 restarts the period at level 5.
        doReset(r);
        step(38);
        lc = cyc + 3;
        pushTicks(lc + 32, 32, 2);
        spdUp = 1'b1;
        step(2);
        checkOutput("p5_level_before", int'(level), 4);
        step(1);
        checkOutput("p5_level_after", int'(level), 5);
        step(2);
        spdUp = 1'b0;
        step(lc + 66 - cyc);
        drain();

        // Ten paused cycles stretch one level-4 period to 74.
        doReset(r);
        exp_q.push_back(r + 64);
        exp_q.push_back(r + 138);
        exp_q.push_back(r + 202);
        step(84);
        en = 1'b0;
        step(10);
        en = 1'b1;
        step(r + 204 - cyc);
        drain();

`ifdef SQUARE_EN
        doReset(r);
        pushTicks(r + 64, 64, 2);
        step(63);
        checkOutput("sq_before", int'(rate_sq), 0);
        step(1);
        checkOutput("sq_first", int'(rate_sq), 1);
        step(36);
        checkOutput("sq_held", int'(rate_sq), 1);
        exp_q.delete();
        doReset(r);
        exp_q.push_back(r + 64);
        step(66);
        checkOutput("sq_after_reset", int'(rate_sq), 1);
        drain();
`else
        checkOutput("sq_tied", int'(rate_sq), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
